// File: rtl/au_incdec_counter.sv
`default_nettype none
// ============================================================================
// Module : au_incdec_counter (with AU_incdec step unit)
// Brief  : Loadable up/down counter with command handshake and burst engine.
// Rev    : 1.0  initial release
// ============================================================================

module AU_incdec #(
   parameter int WIDTH = 8,
   parameter int ARCH  = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic             inc_dec,
   output logic [WIDTH-1:0] z,
   output logic             c_out
);
   localparam int c_LVLS = $clog2(WIDTH);

   logic [WIDTH-1:0] w_p;      // bits that pass the carry (inc) or borrow (dec)
   logic [WIDTH-1:0] w_g;      // w_g[i] = AND of w_p[i:0]
   logic [WIDTH:0]   w_carry;

   assign w_p = a ^ {WIDTH{inc_dec}};

   generate
      if (ARCH == 0) begin : g_ripple
         always_comb begin
            logic v_acc;
            v_acc = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
               v_acc  = v_acc & w_p[i];
               w_g[i] = v_acc;
            end
         end
      end else begin : g_prefix
         // ARCH 1 builds a Sklansky tree, ARCH 2 a Kogge-Stone tree
         for (genvar k = 0; k < c_LVLS; k++) begin : g_lvl
            logic [WIDTH-1:0] w_in;
            logic [WIDTH-1:0] w_out;
            if (k == 0) begin : g_first
               assign w_in = w_p;
            end else begin : g_next
               assign w_in = g_lvl[k-1].w_out;
            end
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
               if (ARCH == 1 && ((i >> k) & 1) == 1) begin : g_skl
                  assign w_out[i] = w_in[i] & w_in[((i >> k) << k) - 1];
               end else if (ARCH != 1 && i >= (1 << k)) begin : g_ks
                  assign w_out[i] = w_in[i] & w_in[i - (1 << k)];
               end else begin : g_pass
                  assign w_out[i] = w_in[i];
               end
            end
         end
         if (c_LVLS == 0) begin : g_single
            assign w_g = w_p;
         end else begin : g_last
            assign w_g = g_lvl[c_LVLS-1].w_out;
         end
      end
   endgenerate

   assign w_carry = {w_g, 1'b1};
   assign z       = a ^ w_carry[WIDTH-1:0];
   assign c_out   = w_carry[WIDTH];
endmodule

module au_incdec_counter #(
   parameter int WIDTH = 8,
   parameter int ARCH  = 0,
   parameter int LEN_W = 4,
   parameter int SAT   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] cnt,
   output logic             zero,
   output logic             ovf,
   output logic             busy,
   output logic             done
);
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [1:0] c_OP_LOAD = 2'b00;
   localparam logic [1:0] c_OP_CLR  = 2'b11;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_cnt, w_cnt_nxt, w_step_val;
   logic [LEN_W-1:0] r_rem, w_rem_nxt;
   logic             r_dir, w_dir_nxt;
   logic             r_zero, r_ovf, r_done;
   logic             w_ovf_nxt, w_done_nxt, w_ovf_set, w_ovf_kill;
   logic             w_accept, w_step_en, w_step_dir, w_step_ovf;

   assign cmd_ready = (r_state == ST_IDLE) & ~rst;
   assign w_accept  = cmd_valid & cmd_ready;
   // The first step of a burst is taken on the accept edge, before r_dir is latched
   assign w_step_dir = (r_state == ST_IDLE) ? cmd_op[1] : r_dir;

   AU_incdec #(.WIDTH(WIDTH), .ARCH(ARCH)) u_incdec (
      .a       (r_cnt),
      .inc_dec (w_step_dir),
      .z       (w_step_val),
      .c_out   (w_step_ovf)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rem_nxt   = r_rem;
      w_dir_nxt   = r_dir;
      w_done_nxt  = 1'b0;
      w_step_en   = 1'b0;
      w_ovf_kill  = ovf_clr;
      if (r_state == ST_IDLE) begin
         if (w_accept) begin
            case (cmd_op)
               c_OP_LOAD: begin
                  w_cnt_nxt  = cmd_data;
                  w_done_nxt = 1'b1;
               end
               c_OP_CLR: begin
                  w_cnt_nxt  = '0;
                  w_ovf_kill = 1'b1;
                  w_done_nxt = 1'b1;
               end
               default: begin
                  w_step_en = 1'b1;
                  w_dir_nxt = cmd_op[1];
                  if (cmd_len == '0) begin
                     w_done_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_RUN;
                     w_rem_nxt   = cmd_len;
                  end
               end
            endcase
         end
      end else begin
         w_step_en = 1'b1;
         w_rem_nxt = r_rem - LEN_W'(1);
         if (r_rem == LEN_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
         end
      end
      // A saturating counter keeps its value but still reports the event
      w_ovf_set = w_step_en & w_step_ovf;
      if (w_step_en && !(w_step_ovf && SAT != 0)) begin
         w_cnt_nxt = w_step_val;
      end
      w_ovf_nxt = w_ovf_set | (r_ovf & ~w_ovf_kill);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_dir   <= 1'b0;
         r_zero  <= 1'b1;
         r_ovf   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rem   <= w_rem_nxt;
         r_dir   <= w_dir_nxt;
         r_zero  <= (w_cnt_nxt == '0);
         r_ovf   <= w_ovf_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign cnt  = r_cnt;
   assign zero = r_zero;
   assign ovf  = r_ovf;
   assign busy = (r_state == ST_RUN);
   assign done = r_done;
endmodule
`default_nettype wire

// File: doc/au_incdec_counter.md
Name: au_incdec_counter

Overview:
- Registered up/down counter with a command handshake and a burst (repeat) engine.
- Each step is computed by one instance of the combinational incrementer-decrementer AU_incdec, which is parameterised by WIDTH and ARCH. The counter register and control FSM sit directly downstream of it and consume its result every cycle.
- Used as a loadable event/address counter for arithmetic-unit sequencing.

Parameters:
- WIDTH, 8, counter word length (>= 1); passed to AU_incdec.
- ARCH, 0, prefix architecture (0 to 2); passed to AU_incdec.
- LEN_W, 4, width of burst length field (>= 1).
- SAT, 0, overflow policy: 0 = wrap-around, 1 = saturate (hold at bound).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command valid.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  input  2  00 load, 01 increment, 10 decrement, 11 clear.
- cmd_data  input  WIDTH  load value; used by op 00 only.
- cmd_len  input  LEN_W  burst length; inc/dec performs cmd_len+1 steps.
- ovf_clr  input  1  clears the sticky ovf flag.
- cnt  output  WIDTH  registered counter value.
- zero  output  1  registered, equals (cnt == 0).
- ovf  output  1  sticky flag for wrap/saturation event.
- busy  output  1  high while a multi-step burst is in progress.
- done  output  1  one-cycle registered pulse when a command completes.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - cnt=0, zero=1, ovf=0, busy=0, done=0, FSM=IDLE, remaining-step counter=0.
  - cmd_ready is forced 0 while rst is high, and commands presented during reset are ignored.
  - Reset mid-burst aborts the burst with no done pulse.
- FSM states are IDLE and RUN.
  - cmd_ready = (state==IDLE) & ~rst.
  - busy = (state==RUN), registered.
- Accept at edge k in IDLE:
  - load: cnt <= cmd_data; done=1 in cycle k+1; stay IDLE. ovf unaffected.
  - clear: cnt <= 0 and ovf <= 0; done=1 in cycle k+1; stay IDLE.
  - inc/dec: the first step is applied at edge k and the direction is latched.
    - If cmd_len==0: stay IDLE; done=1 in cycle k+1.
    - Otherwise: go to RUN with remaining=cmd_len.
- RUN:
  - Every edge applies one step in the latched direction and decrements remaining.
  - When a step is applied with remaining==1, the FSM returns to IDLE and done=1 in the following cycle.
  - Total latency from accept to done = cmd_len+1 cycles.
  - Back-to-back commands are accepted with no bubble after a single-cycle command.
- Step arithmetic:
  - next = AU_incdec(a=cnt, inc_dec=dir), with dir 0 = +1 and 1 = -1, modulo 2^WIDTH.
  - Overflow condition: increment with cnt = all ones, or decrement with cnt = 0.
    - SAT=0: the wrapped value is stored and ovf <= 1.
    - SAT=1: cnt is held, ovf <= 1, and the remaining burst steps still consume cycles.
- ovf:
  - Set has priority over ovf_clr in the same cycle.
  - ovf_clr coinciding with a clear command: result 0.
  - ovf_clr is honoured in any state.
- zero and done are registered; they are coincident with the cnt value they describe.
- WIDTH==1:
  - The counter toggles each step.
  - Overflow occurs on inc from 1 and on dec from 0.

Test Plan:
- Reset, then idle → cnt=0, zero=1, ovf=0, cmd_ready=1 from the first cycle after rst deasserts. Assert rst mid-burst (inc len=7 after 3 steps) → cnt=0, busy=0, no done pulse.
- WIDTH=8: load 0x3C, then inc len=0 back-to-back → cnt=0x3C then 0x3D. done high in each following cycle; cmd_ready never drops.
- load 0xFD, inc len=4, SAT=0 → cnt sequence FE, FF, 00, 01, 02. ovf set on the FF→00 step; busy high for 4 cycles; done 5 cycles after accept.
- SAT=1: load 0x02, dec len=5 → cnt 01, 00, 00, 00, 00, 00. ovf=1, zero=1, done after 6 cycles.
- With ovf=1, pulse ovf_clr in the same cycle as a wrapping step → ovf stays 1. Pulse ovf_clr alone → ovf=0. Issue a clear command → cnt=0, ovf=0.
- Sweep ARCH 0..2 and WIDTH {1,2,8,17} with random op/len streams and random cmd_valid gaps → cnt matches the reference model modulo 2^WIDTH. No command is accepted while busy=1.
